// File: rtl/pin_event_monitor.sv
// Pin activity checker: synchronises CHANNELS pins, counts qualifying edges, reports pass or timeout.
// Latency: pin change to edge_pulse is SYNC_STAGES+1 clk; done/pass/timeout follow the deciding cycle by 1 clk.
// Backpressure: none; pins are sampled every clk and no input is ever stalled.
module pin_event_monitor #(
    parameter int CHANNELS       = 4,
    parameter int CNT_W          = 8,
    parameter int EDGES_REQ      = 4,
    parameter int EDGE_MODE      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       chan_mask,
    input  logic [CHANNELS-1:0]       chan_in,
    output logic [CHANNELS-1:0]       edge_pulse,
    output logic [CHANNELS*CNT_W-1:0] edge_count,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout
);

    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int               TMR_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(EDGES_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q;
    state_t              state_nx;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] qual;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_nx [CHANNELS];
    logic [CHANNELS-1:0] mask_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                go;
    logic                complete;
    logic                expired;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign go      = start && (state_q != RUN);
    assign expired = TMO_EN && (tmr_q == TMR_LAST);

    // Synchroniser chain per pin; prev_q always tracks the synced value so a start reloads it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= chan_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= synced;
        end
    end

    // Select which transitions qualify as edges
    always_comb begin
        case (EDGE_MODE)
            0:       qual = synced & ~prev_q;
            1:       qual = ~synced & prev_q;
            default: qual = synced ^ prev_q;
        endcase
    end

    // Registered edge strobe; a transition seen in the start cycle predates the measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) edge_pulse <= '0;
        else     edge_pulse <= qual & ~{CHANNELS{go}};
    end

    // Saturating count update and completion test, including this cycle's strobe
    always_comb begin
        complete = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nx[i] = cnt_q[i];
            if (edge_pulse[i] && (cnt_q[i] != CNT_MAX)) cnt_nx[i] = cnt_q[i] + CNT_W'(1);
            if (mask_q[i] && (cnt_nx[i] < CNT_REQ)) complete = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    // FSM next state: completion has priority over expiry when both hit together
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (complete || expired) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Counters, timer, latched mask and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            tmr_q   <= '0;
            mask_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            if (go) begin
                for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
                tmr_q   <= '0;
                mask_q  <= chan_mask;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end else if (state_q == RUN) begin
                for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_nx[i];
                if (tmr_q != TMR_MAX) tmr_q <= tmr_q + TMR_W'(1);
                if (state_nx == DONE) begin
                    pass    <= complete;
                    timeout <= ~complete;
                end
            end
        end
    end

    // Flatten per-channel counters onto the output bus
    for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
        assign edge_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule
